// File: rtl/two_source_rr_arbiter_pkg.sv
// Shared types for the two-source round-robin arbiter:
// FSM state encoding, source IDs and burst-counter sizing.
package two_source_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic int cnt_width(input int mb);
    return (mb > 1) ? $clog2(mb) : 1;
  endfunction

endpackage

// File: rtl/two_source_rr_arbiter_if.sv
// Handshake bundle: two valid/ready sources in,
// one registered stream out, plus the mux select.
interface two_source_rr_arbiter_if #(
  parameter int N = 5
);
  logic [N-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] b_data;
  logic         b_valid;
  logic         b_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         grant_sel;

  modport slave (
    input  a_data, a_valid, b_data, b_valid, out_ready,
    output a_ready, b_ready, out_data, out_valid, grant_sel
  );

  modport master (
    output a_data, a_valid, b_data, b_valid, out_ready,
    input  a_ready, b_ready, out_data, out_valid, grant_sel
  );
endinterface

// File: rtl/N_bit_two_to_one_mux.sv
// Plain N-bit 2:1 mux; sel = 0 picks a, sel = 1 picks b.
// Kept as a reusable leaf so the datapath stays shared.
module N_bit_two_to_one_mux #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N-1:0] out
);

  assign out = sel ? b : a;

endmodule

// File: rtl/two_source_rr_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one mux
// between sources A and B, feeding a one-entry output register.
module two_source_rr_arbiter
  import two_source_rr_arbiter_pkg::*;
#(
  parameter int N         = 5,
  parameter int MAX_BURST = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  two_source_rr_arbiter_if.slave bus
);

  localparam int CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [N-1:0]    out_data_q;
  logic            out_valid_q;
  logic [N-1:0]    mux_out;
  logic            space;
  logic            sel;
  logic            xfer_a;
  logic            xfer_b;
  logic            burst_end;

  assign space     = !out_valid_q || bus.out_ready;
  assign sel       = (state_q == GRANT_B);
  assign xfer_a    = bus.a_valid && bus.a_ready;
  assign xfer_b    = bus.b_valid && bus.b_ready;
  assign burst_end = (cnt_q == CNT_LAST);

  assign bus.a_ready   = (state_q == GRANT_A) && space;
  assign bus.b_ready   = (state_q == GRANT_B) && space;
  assign bus.grant_sel = sel;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

  N_bit_two_to_one_mux #(.N(N)) u_mux (
    .a   (bus.a_data),
    .b   (bus.b_data),
    .sel (sel),
    .out (mux_out)
  );

  // Arbitration state, burst count and last-served source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SRC_B;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next grant: fair pick in IDLE, hand-off on drop or burst end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.a_valid && (!bus.b_valid || last_q == SRC_B)) begin
          state_d = GRANT_A;
          last_d  = SRC_A;
        end else if (bus.b_valid) begin
          state_d = GRANT_B;
          last_d  = SRC_B;
        end
      end
      GRANT_A: begin
        if (!bus.a_valid) begin
          cnt_d   = '0;
          state_d = bus.b_valid ? GRANT_B : IDLE;
          last_d  = bus.b_valid ? SRC_B : last_q;
        end else if (xfer_a) begin
          if (burst_end) begin
            cnt_d = '0;
            if (bus.b_valid) begin
              state_d = GRANT_B;
              last_d  = SRC_B;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      GRANT_B: begin
        if (!bus.b_valid) begin
          cnt_d   = '0;
          state_d = bus.a_valid ? GRANT_A : IDLE;
          last_d  = bus.a_valid ? SRC_A : last_q;
        end else if (xfer_b) begin
          if (burst_end) begin
            cnt_d = '0;
            if (bus.a_valid) begin
              state_d = GRANT_A;
              last_d  = SRC_A;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: capture on accept, drain when downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (xfer_a || xfer_b) begin
      out_data_q  <= mux_out;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
